// File: rtl/blit_pkg.sv
// Shared constants for the blitter bus-master sequencer.
// Holds the FSM state codes, the transfer width codes and the bus-request bit positions.
package blit_pkg;

    // Sequencer states (legacy-compatible encoded constants)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_OWN     = 3'd2;
    localparam logic [2:0] ST_CYCLE   = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Transfer width codes (value = number of bytes)
    localparam logic [3:0] W8  = 4'd1;
    localparam logic [3:0] W16 = 4'd2;
    localparam logic [3:0] W32 = 4'd4;
    localparam logic [3:0] W64 = 4'd8;

    // Bit positions inside blit_breq
    localparam int BREQ_NORM = 0;
    localparam int BREQ_HI   = 1;

    // Burst counter width: enough bits to hold MAX_BURST, never less than one bit.
    function automatic int burstCntWidth(input int maxBurst);
        if (maxBurst <= 0) begin
            return 1;
        end
        return $clog2(maxBurst + 1);
    endfunction

endpackage

// File: rtl/blit_bus_ctl.sv
// Bus-master sequencer sitting between the blitter core and the TOM bus.
// Takes one memory cycle at a time, arbitrates for the bus, drives the cycle
// while owner, returns the completion (and read data), and gives the bus back
// at end of burst, after MAX_BURST cycles, or when the grant is withdrawn.
module blit_bus_ctl
    import blit_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic        sys_clk,
    input  logic        xreset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [23:0] req_addr,
    input  logic [3:0]  req_width,
    input  logic        req_justify,
    input  logic [63:0] req_wdata,
    input  logic        req_last,
    input  logic        req_hipri,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  blit_breq,
    input  logic        blit_back,
    input  logic        ack,
    input  logic [63:0] data,
    output logic        bus_oe,
    output logic        mreq_out,
    output logic        read_out,
    output logic        justify_out,
    output logic [3:0]  width_out,
    output logic [23:0] blit_addr_out,
    output logic [63:0] wdata_out,
    output logic        idle
);

    localparam int               CNT_W       = burstCntWidth(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    logic [2:0]       state_q,     state_d;
    logic             pri_q,       pri_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             last_q,      last_d;
    logic             ready_q,     ready_d;
    logic [1:0]       breq_q,      breq_d;
    logic             oe_q,        oe_d;
    logic             mreq_q,      mreq_d;
    logic             read_q,      read_d;
    logic             justify_q,   justify_d;
    logic [3:0]       width_q,     width_d;
    logic [23:0]      addr_q,      addr_d;
    logic [63:0]      wdata_q,     wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rdata_q,     rdata_d;
    logic             idle_q,      idle_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             burst_full;

    // Next-state and next-output logic; every output is derived from the state being entered.
    always_comb begin
        state_d     = state_q;
        pri_d       = pri_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        read_d      = read_q;
        justify_d   = justify_q;
        width_d     = width_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;

        accept     = (state_q == ST_OWN) && req_valid && ready_q;
        cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        burst_full = (MAX_BURST != 0) && (cnt_inc == BURST_LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_REQ;
                    pri_d   = req_hipri;
                end
            end
            ST_REQ: begin
                if (blit_back) begin
                    state_d = ST_OWN;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (accept) begin
                    state_d   = ST_CYCLE;
                    read_d    = req_read;
                    addr_d    = req_addr;
                    width_d   = req_width;
                    justify_d = req_justify;
                    wdata_d   = req_wdata;
                    last_d    = req_last;
                end else if (!blit_back) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_CYCLE: begin
                if (ack) begin
                    if (read_q) begin
                        rdata_d = data;
                    end
                    rsp_valid_d = 1'b1;
                    cnt_d       = cnt_inc;
                    if (last_q || burst_full || !blit_back) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_OWN;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        breq_d            = 2'b00;
        if ((state_d == ST_REQ) || (state_d == ST_OWN) || (state_d == ST_CYCLE)) begin
            breq_d[BREQ_HI]   = pri_d;
            breq_d[BREQ_NORM] = !pri_d;
        end
        oe_d    = (state_d == ST_OWN) || (state_d == ST_CYCLE);
        mreq_d  = (state_d == ST_CYCLE);
        ready_d = (state_d == ST_OWN) && blit_back;
        idle_d  = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset is synchronous and overrides everything, including a live cycle.
    always_ff @(posedge sys_clk) begin
        if (!xreset_n) begin
            state_q     <= ST_IDLE;
            pri_q       <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            ready_q     <= 1'b0;
            breq_q      <= 2'b00;
            oe_q        <= 1'b0;
            mreq_q      <= 1'b0;
            read_q      <= 1'b0;
            justify_q   <= 1'b0;
            width_q     <= 4'd0;
            addr_q      <= 24'd0;
            wdata_q     <= 64'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 64'd0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pri_q       <= pri_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            ready_q     <= ready_d;
            breq_q      <= breq_d;
            oe_q        <= oe_d;
            mreq_q      <= mreq_d;
            read_q      <= read_d;
            justify_q   <= justify_d;
            width_q     <= width_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            idle_q      <= idle_d;
        end
    end

    assign req_ready     = ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign blit_breq     = breq_q;
    assign bus_oe        = oe_q;
    assign mreq_out      = mreq_q;
    assign read_out      = read_q;
    assign justify_out   = justify_q;
    assign width_out     = width_q;
    assign blit_addr_out = addr_q;
    assign wdata_out     = wdata_q;
    assign idle          = idle_q;

endmodule

// File: tb/tb_blit_bus_ctl.sv
// Bench for blit_bus_ctl: a bus arbiter model, a memory model and a scoreboard
// that holds expected bus cycles and responses in issue order.
module tb_blit_bus_ctl;
    import blit_pkg::*;

    typedef struct packed {
        logic        read;
        logic [23:0] addr;
        logic [3:0]  width;
        logic        justify;
        logic [63:0] wdata;
    } busExp_t;

    logic        clk        = 1'b0;
    logic        xresetN    = 1'b0;
    logic        reqValid   = 1'b0;
    logic        reqRead    = 1'b0;
    logic        reqJustify = 1'b0;
    logic        reqLast    = 1'b0;
    logic        reqHipri   = 1'b0;
    logic [23:0] reqAddr    = '0;
    logic [3:0]  reqWidth   = '0;
    logic [63:0] reqWdata   = '0;
    logic        blitBack   = 1'b0;
    logic        ackModel   = 1'b0;
    logic        ackForce   = 1'b0;
    logic [63:0] memData    = '0;
    logic        ack;
    logic        useB       = 1'b0;

    logic        reqReadyA, rspValidA, busOeA, mreqA, readOutA, justifyOutA, idleA;
    logic [63:0] rspRdataA, wdataOutA;
    logic [1:0]  breqA;
    logic [3:0]  widthOutA;
    logic [23:0] addrOutA;
    logic        reqReadyB, rspValidB, busOeB, mreqB, readOutB, justifyOutB, idleB;
    logic [63:0] rspRdataB, wdataOutB;
    logic [1:0]  breqB;
    logic [3:0]  widthOutB;
    logic [23:0] addrOutB;

    logic        reqReady, rspValid, busOe, mreq, readOut, justifyOut, idle;
    logic [63:0] rspRdata, wdataOut;
    logic [1:0]  breq;
    logic [3:0]  widthOut;
    logic [23:0] addrOut;

    int          checks = 0;
    int          errors = 0;

    int          backDelay  = 0;
    int          ackDelay   = 0;
    logic        memEnable  = 1'b1;
    logic        dropOnMreq = 1'b0;
    int          testId     = 0;

    int          backWait = 0, ackWait = 0;
    logic        backBlocked = 1'b0;
    int          seenTestId = 0, cycleNo = 0;
    int          grants = 0, rspCount = 0, mreqRises = 0, mreqHigh = 0, breqFalls = 0;
    int          lastRise = -1, minGap = 1000, maxGap = 0, grantCycle = 0, grantToMreq = -1;
    logic        mreqPrev = 1'b0, relPending = 1'b0;
    logic [1:0]  breqPrev = 2'b00, breqSeen = 2'b00;

    busExp_t     busQ[$];
    logic [63:0] rspQ[$];
    logic [63:0] rdataModel = '0;

    assign ack = ackModel | ackForce;

    assign reqReady   = useB ? reqReadyB   : reqReadyA;
    assign rspValid   = useB ? rspValidB   : rspValidA;
    assign busOe      = useB ? busOeB      : busOeA;
    assign mreq       = useB ? mreqB       : mreqA;
    assign readOut    = useB ? readOutB    : readOutA;
    assign justifyOut = useB ? justifyOutB : justifyOutA;
    assign idle       = useB ? idleB       : idleA;
    assign rspRdata   = useB ? rspRdataB   : rspRdataA;
    assign wdataOut   = useB ? wdataOutB   : wdataOutA;
    assign breq       = useB ? breqB       : breqA;
    assign widthOut   = useB ? widthOutB   : widthOutA;
    assign addrOut    = useB ? addrOutB    : addrOutA;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    blit_bus_ctl #(.MAX_BURST(16)) dutA (
        .sys_clk(clk), .xreset_n(xresetN), .req_valid(reqValid), .req_ready(reqReadyA),
        .req_read(reqRead), .req_addr(reqAddr), .req_width(reqWidth), .req_justify(reqJustify),
        .req_wdata(reqWdata), .req_last(reqLast), .req_hipri(reqHipri), .rsp_valid(rspValidA),
        .rsp_rdata(rspRdataA), .blit_breq(breqA), .blit_back(blitBack), .ack(ack), .data(memData),
        .bus_oe(busOeA), .mreq_out(mreqA), .read_out(readOutA), .justify_out(justifyOutA),
        .width_out(widthOutA), .blit_addr_out(addrOutA), .wdata_out(wdataOutA), .idle(idleA));

    blit_bus_ctl #(.MAX_BURST(2)) dutB (
        .sys_clk(clk), .xreset_n(xresetN), .req_valid(reqValid), .req_ready(reqReadyB),
        .req_read(reqRead), .req_addr(reqAddr), .req_width(reqWidth), .req_justify(reqJustify),
        .req_wdata(reqWdata), .req_last(reqLast), .req_hipri(reqHipri), .rsp_valid(rspValidB),
        .rsp_rdata(rspRdataB), .blit_breq(breqB), .blit_back(blitBack), .ack(ack), .data(memData),
        .bus_oe(busOeB), .mreq_out(mreqB), .read_out(readOutB), .justify_out(justifyOutB),
        .width_out(widthOutB), .blit_addr_out(addrOutB), .wdata_out(wdataOutB), .idle(idleB));

    // Memory contents are a fixed function of the address so reads are predictable
    function automatic logic [63:0] memValue(input logic [23:0] a);
        return {a, 16'hC0DE, ~a};
    endfunction

    // Counts a comparison and reports it when the observed value differs
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Observes the selected DUT on the falling edge, then advances the arbiter and memory models
    always @(negedge clk) begin
        busExp_t     e;
        logic [63:0] expRdata;
        if (testId != seenTestId) begin
            seenTestId  = testId;
            grants      = 0;
            rspCount    = 0;
            mreqRises   = 0;
            mreqHigh    = 0;
            breqFalls   = 0;
            lastRise    = -1;
            minGap      = 1000;
            maxGap      = 0;
            grantToMreq = -1;
            breqSeen    = 2'b00;
            relPending  = 1'b0;
        end
        cycleNo++;

        if (rspValid) begin
            rspCount++;
            checkOutput("rspQueueNonEmpty", rspQ.size() != 0, 1);
            if (rspQ.size() != 0) begin
                expRdata = rspQ.pop_front();
                checkOutput("rspRdata", rspRdata, expRdata);
            end
        end

        if (mreq && !mreqPrev) begin
            mreqRises++;
            checkOutput("busQueueNonEmpty", busQ.size() != 0, 1);
            if (busQ.size() != 0) begin
                e = busQ.pop_front();
                checkOutput("addrOut", addrOut, e.addr);
                checkOutput("wdataOut", wdataOut, e.wdata);
                checkOutput("widthOut", widthOut, e.width);
                checkOutput("readOut", readOut, e.read);
                checkOutput("justifyOut", justifyOut, e.justify);
                checkOutput("busOeInCycle", busOe, 1);
            end
            if (lastRise >= 0) begin
                if (cycleNo - lastRise < minGap) minGap = cycleNo - lastRise;
                if (cycleNo - lastRise > maxGap) maxGap = cycleNo - lastRise;
            end
            lastRise    = cycleNo;
            grantToMreq = cycleNo - grantCycle;
        end
        if (mreq) mreqHigh++;
        breqSeen = breqSeen | breq;

        if (relPending) begin
            checkOutput("releaseOneCycle", idle, 1);
            relPending = 1'b0;
        end
        if ((breqPrev != 2'b00) && (breq == 2'b00)) begin
            breqFalls++;
            if (!idle) begin
                checkOutput("releaseBusOe", busOe, 0);
                relPending = 1'b1;
            end
        end
        mreqPrev = mreq;
        breqPrev = breq;

        if (!xresetN || (breq == 2'b00)) begin
            blitBack    = 1'b0;
            backWait    = 0;
            backBlocked = 1'b0;
        end else if (backBlocked) begin
            blitBack = 1'b0;
        end else if (dropOnMreq && mreq) begin
            blitBack    = 1'b0;
            backBlocked = 1'b1;
            dropOnMreq  = 1'b0;
        end else if (!blitBack) begin
            if (backWait >= backDelay) begin
                blitBack   = 1'b1;
                grants++;
                grantCycle = cycleNo;
            end else begin
                backWait++;
            end
        end

        ackModel = 1'b0;
        memData  = {$urandom, $urandom};
        if (xresetN && mreq && memEnable) begin
            if (ackWait >= ackDelay) begin
                ackModel = 1'b1;
                memData  = memValue(addrOut);
                ackWait  = 0;
            end else begin
                ackWait++;
            end
        end else begin
            ackWait = 0;
        end
    end

    // Holds a request until accepted, recording the expected bus cycle and response
    task automatic applyStimulus(input logic rd, input logic [23:0] a, input logic [3:0] w,
                                 input logic j, input logic [63:0] wd, input logic lst, input logic hp);
        int      waited;
        busExp_t e;
        @(negedge clk);
        reqValid   = 1'b1;
        reqRead    = rd;
        reqAddr    = a;
        reqWidth   = w;
        reqJustify = j;
        reqWdata   = wd;
        reqLast    = lst;
        reqHipri   = hp;
        waited     = 0;
        while (!reqReady && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("acceptTimeout", reqReady, 1);
        if (!reqReady) begin
            reqValid = 1'b0;
            return;
        end
        e.read    = rd;
        e.addr    = a;
        e.width   = w;
        e.justify = j;
        e.wdata   = wd;
        busQ.push_back(e);
        if (rd) rdataModel = memValue(a);
        rspQ.push_back(rdataModel);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    // Waits for the sequencer to return to idle within a cycle budget
    task automatic waitIdle(input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!idle && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput(tag, idle, 1);
        checkOutput("scoreboardEmpty", busQ.size() + rspQ.size(), 0);
    endtask

    // Resets both DUTs, selects which one the models follow and restores default knobs
    task automatic beginTest(input logic sel);
        @(negedge clk);
        xresetN    = 1'b0;
        reqValid   = 1'b0;
        ackForce   = 1'b0;
        memEnable  = 1'b1;
        dropOnMreq = 1'b0;
        backDelay  = 0;
        ackDelay   = 0;
        @(negedge clk);
        useB = sel;
        testId++;
        @(negedge clk);
        busQ.delete();
        rspQ.delete();
        rdataModel = '0;
        xresetN    = 1'b1;
    endtask

    // Overall time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        reqValid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstIdle", idle, 1);
        checkOutput("rstBreq", breq, 0);
        checkOutput("rstBusOe", busOe, 0);
        checkOutput("rstMreq", mreq, 0);
        checkOutput("rstReady", reqReady, 0);
        checkOutput("rstRspValid", rspValid, 0);
        checkOutput("rstRdata", rspRdata, 0);
        checkOutput("rstAddr", addrOut, 0);
        reqValid = 1'b0;

        $display("[TB] single read");
        beginTest(1'b0);
        backDelay = 3;
        ackDelay  = 1;
        applyStimulus(1'b1, 24'h001234, W8, 1'b0, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
        waitIdle("t1Idle");
        checkOutput("t1BreqNorm", breqSeen, 2'b01);
        checkOutput("t1MreqCycles", mreqHigh, 2);
        checkOutput("t1RspCount", rspCount, 1);
        checkOutput("t1GrantToMreq", grantToMreq, 2);
        checkOutput("t1Rdata", rspRdata, memValue(24'h001234));

        $display("[TB] four-write burst");
        beginTest(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 24'h000100 + 24'(i * 8), W64, i[0], {$urandom, $urandom}, i == 3, 1'b0);
        end
        waitIdle("t2Idle");
        checkOutput("t2Grants", grants, 1);
        checkOutput("t2MreqPulses", mreqRises, 4);
        checkOutput("t2MinGap", minGap, 2);
        checkOutput("t2MaxGap", maxGap, 2);
        checkOutput("t2RspCount", rspCount, 4);
        checkOutput("t2Rdata", rspRdata, 0);

        $display("[TB] burst limit of two");
        beginTest(1'b1);
        backDelay = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 24'hABC000 + 24'(i), W16, 1'b1, {32'hFACE_0000 + 32'(i), $urandom}, i == 4, 1'b0);
        end
        waitIdle("t3Idle");
        checkOutput("t3Grants", grants, 3);
        checkOutput("t3BreqDrops", breqFalls, 3);
        checkOutput("t3RspCount", rspCount, 5);
        checkOutput("t3MreqPulses", mreqRises, 5);

        $display("[TB] high priority with grant loss mid-cycle");
        beginTest(1'b0);
        backDelay  = 2;
        ackDelay   = 1;
        dropOnMreq = 1'b1;
        applyStimulus(1'b1, 24'h7F0010, W32, 1'b0, 64'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 24'h7F0014, W32, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b1);
        waitIdle("t4Idle");
        checkOutput("t4BreqHi", breqSeen, 2'b10);
        checkOutput("t4Grants", grants, 2);
        checkOutput("t4RspCount", rspCount, 2);
        checkOutput("t4BreqDrops", breqFalls, 2);
        checkOutput("t4Rdata", rspRdata, memValue(24'h7F0010));

        $display("[TB] reset during cycle");
        beginTest(1'b0);
        applyStimulus(1'b1, 24'h00BEEF, W8, 1'b0, 64'h0, 1'b1, 1'b0);
        waitIdle("t5FirstIdle");
        memEnable = 1'b0;
        applyStimulus(1'b1, 24'h00CAFE, W8, 1'b0, 64'h0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("t5MreqHeld", mreq, 1);
        xresetN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5RstMreq", mreq, 0);
        checkOutput("t5RstBusOe", busOe, 0);
        checkOutput("t5RstBreq", breq, 0);
        checkOutput("t5RstIdle", idle, 1);
        checkOutput("t5RstRdata", rspRdata, 0);
        @(negedge clk);
        busQ.delete();
        rspQ.delete();
        rdataModel = '0;
        xresetN  = 1'b1;
        ackForce = 1'b1;
        repeat (3) @(negedge clk);
        ackForce = 1'b0;
        @(negedge clk);
        checkOutput("t5NoLateRsp", rspCount, 1);
        checkOutput("t5IdleAfter", idle, 1);

        $display("[TB] ack and grant loss on the same edge");
        beginTest(1'b0);
        dropOnMreq = 1'b1;
        applyStimulus(1'b0, 24'h123400, W32, 1'b0, 64'h0102_0304_0506_0708, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h123404, W32, 1'b1, 64'h0, 1'b1, 1'b0);
        waitIdle("t6Idle");
        checkOutput("t6Grants", grants, 2);
        checkOutput("t6RspCount", rspCount, 2);
        checkOutput("t6MreqPulses", mreqRises, 2);
        checkOutput("t6BreqDrops", breqFalls, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
